// File: rtl/serial_slave.sv
// Slave end of the synchronous serial link: oversamples serial clock/data in the in_clk domain,
// deserialises BITS-bit words and shifts a reply word back out. Optional: SERIAL_SLAVE_FRAME_ERR_EN.
module serial_slave #(
    parameter int BITS                = 8,
    parameter bit LOWBIT_FIRST        = 1'b0,
    parameter bit SERIAL_CLK_INACTIVE = 1'b1,
    parameter int SYNC_STAGES         = 2
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_enable,
    input  logic            in_serial_clk,
    input  logic            in_serial,
    output logic            out_serial,
    input  logic [BITS-1:0] in_parallel,
    output logic [BITS-1:0] out_parallel,
    output logic            out_word_valid,
    output logic            out_next_word,
    output logic            out_ready,
`ifdef SERIAL_SLAVE_FRAME_ERR_EN
    output logic            out_frame_err,
`endif
    output logic            dbg_state
);

    localparam int CNT_W = (BITS > 2) ? $clog2(BITS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, din_sync, en_sync;
    logic                   sclk_prev, en_prev;
    logic                   sclk_s, din_s, en_s;
    logic                   shift_edge, sample_edge, en_rise;
    logic                   do_load, do_abort, do_sample, do_shift;

    logic [CNT_W-1:0]       cnt;
    logic [BITS-1:0]        rx_sr, tx_sr, rx_next, tx_next;
    logic                   first_pend;
    logic                   last_bit;

    // Synchronisers reset to the idle link level so no edge is seen coming out of reset.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            sclk_sync <= {SYNC_STAGES{SERIAL_CLK_INACTIVE}};
            din_sync  <= '0;
            en_sync   <= '0;
            sclk_prev <= SERIAL_CLK_INACTIVE;
            en_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], in_serial_clk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], in_serial};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], in_enable};
            sclk_prev <= sclk_s;
            en_prev   <= en_s;
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign din_s       = din_sync[SYNC_STAGES-1];
    assign en_s        = en_sync[SYNC_STAGES-1];
    assign shift_edge  = (sclk_prev == SERIAL_CLK_INACTIVE) && (sclk_s != SERIAL_CLK_INACTIVE);
    assign sample_edge = (sclk_prev != SERIAL_CLK_INACTIVE) && (sclk_s == SERIAL_CLK_INACTIVE);
    assign en_rise     = en_s && !en_prev;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) state <= IDLE;
        else         state <= state_n;
    end

    // Enable dropping takes priority over a coincident sample edge.
    always_comb begin
        state_n   = state;
        do_load   = 1'b0;
        do_abort  = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        case (state)
            IDLE: begin
                if (en_rise) begin
                    state_n = SHIFT;
                    do_load = 1'b1;
                end
            end
            SHIFT: begin
                if (!en_s) begin
                    state_n  = IDLE;
                    do_abort = 1'b1;
                end else if (sample_edge) begin
                    do_sample = 1'b1;
                end else if (shift_edge) begin
                    do_shift = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_next    = LOWBIT_FIRST ? {din_s, rx_sr[BITS-1:1]} : {rx_sr[BITS-2:0], din_s};
    assign tx_next    = LOWBIT_FIRST ? {1'b0, tx_sr[BITS-1:1]} : {tx_sr[BITS-2:0], 1'b0};
    assign last_bit   = (cnt == CNT_W'(BITS - 1));
    assign out_serial = LOWBIT_FIRST ? tx_sr[0] : tx_sr[BITS-1];
    assign out_ready  = (state == IDLE);
    assign dbg_state  = (state == SHIFT);

    // out_word_valid / out_next_word: single-cycle strobes with no back-pressure; the user
    // must capture out_parallel on out_word_valid and may change in_parallel after out_next_word.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt            <= '0;
            rx_sr          <= '0;
            tx_sr          <= '0;
            first_pend     <= 1'b0;
            out_parallel   <= '0;
            out_word_valid <= 1'b0;
            out_next_word  <= 1'b0;
        end else begin
            out_word_valid <= 1'b0;
            out_next_word  <= 1'b0;
            if (do_load) begin
                cnt           <= '0;
                rx_sr         <= '0;
                tx_sr         <= in_parallel;
                first_pend    <= 1'b1;
                out_next_word <= 1'b1;
            end else if (do_abort) begin
                cnt        <= '0;
                rx_sr      <= '0;
                tx_sr      <= '0;
                first_pend <= 1'b0;
            end else if (do_sample) begin
                rx_sr <= rx_next;
                if (last_bit) begin
                    cnt            <= '0;
                    out_parallel   <= rx_next;
                    out_word_valid <= 1'b1;
                    tx_sr          <= in_parallel;
                    first_pend     <= 1'b1;
                    out_next_word  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (do_shift) begin
                // First bit of each word was already presented at load time.
                if (first_pend) first_pend <= 1'b0;
                else            tx_sr      <= tx_next;
            end
        end
    end

`ifdef SERIAL_SLAVE_FRAME_ERR_EN
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst)                        out_frame_err <= 1'b0;
        else if (do_load)                   out_frame_err <= 1'b0;
        else if (do_abort && (cnt != '0))   out_frame_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_serial_slave.sv
// Bench for serial_slave: an MSB-first and an LSB-first instance share one behavioural master;
// received words and reply bits are checked against expectations derived from the bit stream.
module tb_serial_slave;

    localparam int HALF = 8;  // in_clk cycles per serial clock half period

    logic       in_clk = 1'b0;
    logic       in_rst = 1'b0;
    logic       in_enable = 1'b0;
    logic       in_serial_clk = 1'b1;
    logic       in_serial = 1'b0;
    logic [7:0] in_parallel = 8'h00;

    logic       ser_m, vld_m, nw_m, rdy_m, dbg_m;
    logic       ser_l, vld_l, nw_l, rdy_l, dbg_l;
    logic [7:0] par_m, par_l;
`ifdef SERIAL_SLAVE_FRAME_ERR_EN
    logic       err_m, err_l;
`endif

    always #5 in_clk = ~in_clk;

    serial_slave #(.BITS(8), .LOWBIT_FIRST(1'b0), .SERIAL_CLK_INACTIVE(1'b1), .SYNC_STAGES(2)) u_msb (
        .in_clk(in_clk), .in_rst(in_rst), .in_enable(in_enable), .in_serial_clk(in_serial_clk),
        .in_serial(in_serial), .out_serial(ser_m), .in_parallel(in_parallel), .out_parallel(par_m),
        .out_word_valid(vld_m), .out_next_word(nw_m), .out_ready(rdy_m),
`ifdef SERIAL_SLAVE_FRAME_ERR_EN
        .out_frame_err(err_m),
`endif
        .dbg_state(dbg_m)
    );

    serial_slave #(.BITS(8), .LOWBIT_FIRST(1'b1), .SERIAL_CLK_INACTIVE(1'b1), .SYNC_STAGES(2)) u_lsb (
        .in_clk(in_clk), .in_rst(in_rst), .in_enable(in_enable), .in_serial_clk(in_serial_clk),
        .in_serial(in_serial), .out_serial(ser_l), .in_parallel(in_parallel), .out_parallel(par_l),
        .out_word_valid(vld_l), .out_next_word(nw_l), .out_ready(rdy_l),
`ifdef SERIAL_SLAVE_FRAME_ERR_EN
        .out_frame_err(err_l),
`endif
        .dbg_state(dbg_l)
    );

    // ---------------- monitor (samples on the falling edge) ----------------
    logic [7:0] got_m[512];
    logic [7:0] got_l[512];
    int         got_n_m = 0, got_n_l = 0;
    int         nw_cnt_m = 0, nw_cnt_l = 0;
    int         pw_err = 0;
    logic       vld_m_d = 1'b0, vld_l_d = 1'b0, nw_m_d = 1'b0, nw_l_d = 1'b0;

    always @(negedge in_clk) begin
        if (vld_m) begin
            if (got_n_m < 512) got_m[got_n_m] = par_m;
            got_n_m = got_n_m + 1;
        end
        if (vld_l) begin
            if (got_n_l < 512) got_l[got_n_l] = par_l;
            got_n_l = got_n_l + 1;
        end
        if (nw_m) nw_cnt_m = nw_cnt_m + 1;
        if (nw_l) nw_cnt_l = nw_cnt_l + 1;
        if ((vld_m && vld_m_d) || (vld_l && vld_l_d) || (nw_m && nw_m_d) || (nw_l && nw_l_d))
            pw_err = pw_err + 1;
        vld_m_d = vld_m;
        vld_l_d = vld_l;
        nw_m_d  = nw_m;
        nw_l_d  = nw_l;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q_m[$];
    logic [7:0] exp_q_l[$];
    logic [7:0] last_m = 8'h00, last_l = 8'h00;
    int         rd_m = 0, rd_l = 0;
    int         base_nw_m = 0, base_nw_l = 0;
    int         n_vec = 0, n_err = 0;

    logic [7:0] fr_data[6];
    logic [7:0] fr_reply[6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge in_clk);
        #2;
    endtask

    task automatic frame_begin(input logic [7:0] reply0);
        base_nw_m   = nw_cnt_m;
        base_nw_l   = nw_cnt_l;
        in_parallel = reply0;
        in_enable   = 1'b1;
        wait_cyc(HALF);
        check("msb_ready_busy", rdy_m, 1'b0);
        check("lsb_ready_busy", rdy_l, 1'b0);
`ifdef SERIAL_SLAVE_FRAME_ERR_EN
        check("msb_err_cleared", err_m, 1'b0);
        check("lsb_err_cleared", err_l, 1'b0);
`endif
    endtask

    // Time-ordered bits are data[7] first; the LSB instance therefore sees the bit-reversed word.
    task automatic send_word(input logic [7:0] data, input int nbits,
                             input logic [7:0] reply, input logic [7:0] next_reply);
        for (int i = 0; i < nbits; i++) begin
            in_serial_clk = 1'b0;
            in_serial     = data[7-i];
            if (i == 0) in_parallel = next_reply;
            wait_cyc(HALF);
            in_serial_clk = 1'b1;
            check("msb_reply_bit", ser_m, reply[7-i]);
            check("lsb_reply_bit", ser_l, reply[i]);
            if (i == 7) begin
                exp_q_m.push_back(data);
                exp_q_l.push_back(rev8(data));
                last_m = data;
                last_l = rev8(data);
            end
            wait_cyc(HALF);
        end
    endtask

    task automatic frame_end(input int full_words, input bit truncated);
        in_enable = 1'b0;
        wait_cyc(HALF);
        check("msb_ready_idle", rdy_m, 1'b1);
        check("lsb_ready_idle", rdy_l, 1'b1);
        check("msb_serial_idle", ser_m, 1'b0);
        check("lsb_serial_idle", ser_l, 1'b0);
        check("msb_par_hold", par_m, last_m);
        check("lsb_par_hold", par_l, last_l);
        check("msb_next_word_cnt", nw_cnt_m - base_nw_m, 1 + full_words);
        check("lsb_next_word_cnt", nw_cnt_l - base_nw_l, 1 + full_words);
        check("msb_valid_cnt", got_n_m - rd_m, full_words);
        check("lsb_valid_cnt", got_n_l - rd_l, full_words);
        while (rd_m < got_n_m && rd_m < 512 && exp_q_m.size() > 0) begin
            check("msb_word", got_m[rd_m], exp_q_m.pop_front());
            rd_m++;
        end
        while (rd_l < got_n_l && rd_l < 512 && exp_q_l.size() > 0) begin
            check("lsb_word", got_l[rd_l], exp_q_l.pop_front());
            rd_l++;
        end
        rd_m = got_n_m;
        rd_l = got_n_l;
        exp_q_m.delete();
        exp_q_l.delete();
`ifdef SERIAL_SLAVE_FRAME_ERR_EN
        check("msb_frame_err", err_m, truncated);
        check("lsb_frame_err", err_l, truncated);
`else
        if (truncated) wait_cyc(1);
`endif
    endtask

    task automatic run_frame(input int nw, input int trunc);
        frame_begin(fr_reply[0]);
        for (int k = 0; k < nw; k++) send_word(fr_data[k], 8, fr_reply[k], fr_reply[k+1]);
        if (trunc > 0) send_word(fr_data[nw], trunc, fr_reply[nw], fr_reply[nw+1]);
        frame_end(nw, trunc > 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {rdy_m, rdy_l}, 2'b11);
        check({tag, "_par"}, {par_m, par_l}, 16'h0000);
        check({tag, "_serial"}, {ser_m, ser_l}, 2'b00);
        check({tag, "_strobes"}, {vld_m, vld_l, nw_m, nw_l}, 4'b0000);
`ifdef SERIAL_SLAVE_FRAME_ERR_EN
        check({tag, "_frame_err"}, {err_m, err_l}, 2'b00);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        wait_cyc(3);
        check_reset_outputs("reset");
        in_rst = 1'b1;
        wait_cyc(4);

        // Single word, MSB-first reference pattern with a known reply.
        fr_data[0] = 8'hA5; fr_reply[0] = 8'h3C; fr_reply[1] = 8'h00;
        run_frame(1, 0);

        // Two words back to back in one frame.
        fr_data[0] = 8'h81; fr_data[1] = 8'h7E;
        fr_reply[0] = 8'hC3; fr_reply[1] = 8'h5A; fr_reply[2] = 8'h00;
        run_frame(2, 0);

        // Truncated frame: 5 bits of 8'hFF then enable drops.
        fr_data[0] = 8'hFF; fr_reply[0] = 8'h96; fr_reply[1] = 8'h00;
        run_frame(0, 5);

        // Randomised frames, some ending mid-word.
        for (int f = 0; f < 16; f++) begin
            int nw;
            int trunc;
            nw    = $urandom_range(0, 3);
            trunc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            if (nw == 0 && trunc == 0) nw = 1;
            for (int k = 0; k < 6; k++) begin
                fr_data[k]  = 8'($urandom_range(0, 255));
                fr_reply[k] = 8'($urandom_range(0, 255));
            end
            run_frame(nw, trunc);
        end

        // Asynchronous reset in the middle of a frame.
        frame_begin(8'hE7);
        send_word(8'h5B, 3, 8'hE7, 8'h00);
        #3 in_rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        in_enable     = 1'b0;
        in_serial_clk = 1'b1;
        exp_q_m.delete();
        exp_q_l.delete();
        last_m = 8'h00;
        last_l = 8'h00;
        wait_cyc(3);
        in_rst = 1'b1;
        rd_m = got_n_m;
        rd_l = got_n_l;
        wait_cyc(4);

        // Link works again after reset.
        fr_data[0] = 8'h3C; fr_reply[0] = 8'hA5; fr_reply[1] = 8'h11;
        run_frame(1, 0);

        check("strobe_width_violations", pw_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
